axis_downsizer: RTL and testbench
=================================

// Module: axis_downsizer
// PURPOSE
//  AXI4-Stream width converter, wide-to-narrow, fixed integer ratio.
//  Splits each S_DATA_WIDTH input beat into up to RATIO output lanes, LSB lane first.
//  Sits directly upstream of the skid-buffer axis_register (REG_TYPE=2).
//  That register breaks the m_axis_tready timing path back into this block.
// PARAMETERS
//  S_DATA_WIDTH  64  input tdata width; must equal RATIO*M_DATA_WIDTH
//  RATIO         4   output lanes per input beat, >=2
//  M_DATA_WIDTH  16  output tdata width; multiple of 8
//  USER_WIDTH    1   tuser width
//  S_KEEP_WIDTH = S_DATA_WIDTH/8 and M_KEEP_WIDTH = M_DATA_WIDTH/8 are localparams
// PORTS
//  clk            in   1             clock
//  rstn           in   1             async active-low reset
//  rstn_local     in   1             sync active-low clear
//  s_axis_tdata   in   S_DATA_WIDTH  wide data
//  s_axis_tkeep   in   S_KEEP_WIDTH  byte enables; contiguous from bit 0
//  s_axis_tvalid  in   1             input valid
//  s_axis_tready  out  1             input ready
//  s_axis_tlast   in   1             end of packet
//  s_axis_tuser   in   USER_WIDTH    sideband
//  m_axis_tdata   out  M_DATA_WIDTH  lane data
//  m_axis_tkeep   out  M_KEEP_WIDTH  lane byte enables
//  m_axis_tvalid  out  1             output valid
//  m_axis_tready  in   1             output ready
//  m_axis_tlast   out  1             s_axis_tlast, on final emitted lane only
//  m_axis_tuser   out  USER_WIDTH    copy of s_axis_tuser, on every lane of the beat
// BEHAVIOUR
//  Clocking and reset:
//  - Single clock domain, clk. rstn is asynchronous and active-low.
//  - rstn=0 (async) or rstn_local=0 (sync) clears: m_axis_tvalid=0, lane index=0, holding-reg valid=0.
//  - Datapath registers are not reset.
//  State:
//  - Holding reg: tdata, tkeep, tlast, tuser, plus valid flag.
//  - Lane index idx, 0..RATIO-1.
//  - last_idx: highest lane with any tkeep bit set; 0 if tkeep is all-zero.
//    Computed on capture and stored.
//  FSM:
//  - EMPTY (valid=0): s_axis_tready=1.
//    On s_axis_tvalid, capture beat, idx<=0 -> SEND.
//  - SEND (valid=1): m_axis_tdata = hold_data[idx*M_DATA_WIDTH +: M_DATA_WIDTH].
//    m_axis_tkeep is the same slice of hold_keep.
//  - m_axis_tlast = hold_last && (idx==last_idx).
//  - On m_axis_tvalid && m_axis_tready with idx<last_idx: idx<=idx+1.
//  - On m_axis_tvalid && m_axis_tready with idx==last_idx:
//    if s_axis_tvalid, capture the next beat and set idx<=0 (stay SEND, zero bubble); else -> EMPTY.
//  - s_axis_tready = !valid || (idx==last_idx && m_axis_tready).
//    This is combinational from m_axis_tready; it is the only comb path.
//  Timing:
//  - Latency: first lane valid 1 cycle after input acceptance.
//  - Throughput: (last_idx+1) output beats per input beat, no idle cycles between beats while m_axis_tready=1.
//  Boundary and error cases:
//  - Lanes above last_idx are dropped, so short trailing beats emit fewer lanes.
//  - All-zero tkeep: exactly one lane is emitted, keep=0, carrying tlast/tuser.
//  - m_axis_tready low: outputs hold stable (AXIS rule); idx does not advance.
//  - Reset mid-beat: remaining lanes are discarded; no partial beat is emitted after reset.
//  - Non-contiguous tkeep: lanes are still emitted up to the highest set lane, with keep passed unmodified. Not an error.
// TESTING
//  1. RATIO=4, beat 0x4444_3333_2222_1111, keep=FF, last=1, m_tready=1
//     -> 1111,2222,3333,4444 on consecutive cycles; tlast only on 4444; s_tready low for cycles 1-3.
//  2. Back-to-back beats A,B with tvalid held, m_tready=1
//     -> 8 contiguous output beats with no gap; B accepted on the cycle A's lane 3 handshakes.
//  3. keep=0x07, last=1
//     -> 2 lanes: keep 0x3, then 0x1 with tlast=1; lanes 2-3 not emitted.
//  4. keep=0x00, last=1, user=1
//     -> 1 lane: keep=0, tlast=1, tuser=1.
//  5. Random m_tready toggling over 1000 beats
//     -> output sequence matches the scoreboard; data stable while valid && !ready.
//  6. Assert rstn_local=0 during lane 2 of a beat -> next cycle m_tvalid=0, s_tready=1.
//     Then send new beat -> lane 0 of the new beat is output first.

Source files
------------

// File: rtl/axis_downsizer.sv
// axis_downsizer: AXI4-Stream wide-to-narrow width converter with a fixed
// integer ratio. Each accepted input beat is held in a single register and
// emitted as up to RATIO narrow lanes, least-significant lane first. Lanes
// above the highest lane carrying any byte enable are dropped. The next input
// beat is accepted on the same cycle the final lane handshakes, so a
// continuous stream flows with no bubbles.
module axis_downsizer #(
  parameter int S_DATA_WIDTH = 64,
  parameter int RATIO        = 4,
  parameter int M_DATA_WIDTH = 16,
  parameter int USER_WIDTH   = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      rstn_local,
  input  logic [S_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic [USER_WIDTH-1:0]     s_axis_tuser,
  output logic [M_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [USER_WIDTH-1:0]     m_axis_tuser
);

  localparam int S_KEEP_WIDTH = S_DATA_WIDTH / 8;
  localparam int M_KEEP_WIDTH = M_DATA_WIDTH / 8;
  localparam int IDX_W        = $clog2(RATIO);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        r_last_idx;
  logic [S_DATA_WIDTH-1:0] r_data;
  logic [S_KEEP_WIDTH-1:0] r_keep;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;

  logic                    w_valid;
  logic                    w_at_last;
  logic                    w_s_hs;
  logic [M_DATA_WIDTH-1:0] w_lane_data;
  logic [M_KEEP_WIDTH-1:0] w_lane_keep;

  // Highest lane that carries at least one byte enable; lane 0 when the
  // whole keep vector is zero so that such a beat still emits one lane.
  function automatic logic [IDX_W-1:0] f_last_idx(input logic [S_KEEP_WIDTH-1:0] keep);
    logic [IDX_W-1:0] v_idx;
    v_idx = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (|keep[i*M_KEEP_WIDTH +: M_KEEP_WIDTH]) begin
        v_idx = IDX_W'(i);
      end
    end
    return v_idx;
  endfunction

  assign w_valid   = (r_state == ST_SEND);
  assign w_at_last = (r_idx == r_last_idx);

  // The only combinational path through the block: m_axis_tready lets the
  // next beat in on the cycle the final lane leaves.
  assign s_axis_tready = !w_valid || (w_at_last && m_axis_tready);
  assign w_s_hs        = s_axis_tvalid && s_axis_tready;

  // Control FSM: tracks whether the holding register is occupied and which lane is on the bus.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_EMPTY;
      r_idx   <= '0;
    end else if (!rstn_local) begin
      r_state <= ST_EMPTY;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (s_axis_tvalid) begin
            r_state <= ST_SEND;
            r_idx   <= '0;
          end
        end
        ST_SEND: begin
          if (m_axis_tready) begin
            if (!w_at_last) begin
              r_idx <= r_idx + 1'b1;
            end else if (s_axis_tvalid) begin
              r_idx <= '0;
            end else begin
              r_state <= ST_EMPTY;
              r_idx   <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // Holding register: captures the whole wide beat and its last-lane index on input handshake.
  always_ff @(posedge clk) begin
    if (w_s_hs) begin
      r_data     <= s_axis_tdata;
      r_keep     <= s_axis_tkeep;
      r_last     <= s_axis_tlast;
      r_user     <= s_axis_tuser;
      r_last_idx <= f_last_idx(s_axis_tkeep);
    end
  end

  // Lane select: picks the current narrow slice of the held beat.
  always_comb begin
    w_lane_data = r_data[M_DATA_WIDTH-1:0];
    w_lane_keep = r_keep[M_KEEP_WIDTH-1:0];
    for (int i = 0; i < RATIO; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_lane_data = r_data[i*M_DATA_WIDTH +: M_DATA_WIDTH];
        w_lane_keep = r_keep[i*M_KEEP_WIDTH +: M_KEEP_WIDTH];
      end
    end
  end

  assign m_axis_tvalid = w_valid;
  assign m_axis_tdata  = w_lane_data;
  assign m_axis_tkeep  = w_lane_keep;
  assign m_axis_tlast  = r_last && w_at_last;
  assign m_axis_tuser  = r_user;

endmodule

// File: tb/tb_axis_downsizer.sv
// tb_axis_downsizer: directed cycle-by-cycle vectors for the downsizer, a few
// hand-written reset sequences, and a randomized backpressure run against a
// lane scoreboard.
`timescale 1ns/1ps
module tb_axis_downsizer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rstn_local;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [0:0]  s_user;
  logic [15:0] m_data;
  logic [1:0]  m_keep;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [0:0]  m_user;

  int n_cmp = 0;
  int n_bad = 0;

  axis_downsizer #(
    .S_DATA_WIDTH(64),
    .RATIO(4),
    .M_DATA_WIDTH(16),
    .USER_WIDTH(1)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rstn_local(rstn_local),
    .s_axis_tdata(s_data),
    .s_axis_tkeep(s_keep),
    .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready),
    .s_axis_tlast(s_last),
    .s_axis_tuser(s_user),
    .m_axis_tdata(m_data),
    .m_axis_tkeep(m_keep),
    .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready),
    .m_axis_tlast(m_last),
    .m_axis_tuser(m_user)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [63:0] sd;
    logic [7:0]  sk;
    logic        sl;
    logic        su;
    logic        mr;
    logic        ev;
    logic [15:0] ed;
    logic [1:0]  ek;
    logic        el;
    logic        eu;
    logic        er;
  } vec_t;

  vec_t        vecs[$];
  logic [19:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One directed cycle: inputs driven for the cycle, outputs expected during it.
  task automatic row(input int sv, input logic [63:0] sd, input logic [7:0] sk,
                     input int sl, input int su, input int mr,
                     input int ev, input logic [15:0] ed, input logic [1:0] ek,
                     input int el, input int eu, input int er);
    vec_t v;
    v.sv = (sv != 0); v.sd = sd; v.sk = sk; v.sl = (sl != 0); v.su = (su != 0);
    v.mr = (mr != 0); v.ev = (ev != 0); v.ed = ed; v.ek = ek;
    v.el = (el != 0); v.eu = (eu != 0); v.er = (er != 0);
    vecs.push_back(v);
  endtask

  // Reference lane expansion of one accepted input beat.
  task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    int li;
    li = 0;
    for (int j = 0; j < 4; j++) begin
      if (k[2*j +: 2] != 2'b00) li = j;
    end
    for (int j = 0; j <= li; j++) begin
      exp_q.push_back({d[16*j +: 16], k[2*j +: 2], (l && (j == li)), u});
    end
  endtask

  initial begin
    int          gen;
    int          cyc;
    int          nb;
    logic        s_acc;
    logic        stall_prev;
    logic [19:0] hold_prev;

    rstn = 1'b0; rstn_local = 1'b1;
    s_data = '0; s_keep = '0; s_valid = 1'b0; s_last = 1'b0; s_user = '0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset m_valid", 64'(m_valid), 64'd0);
    chk("reset s_ready", 64'(s_ready), 64'd1);
    rstn = 1'b1;
    step();

    // Single full beat, continuous ready
    row(1, 64'h4444_3333_2222_1111, 8'hFF, 1, 0, 1,  0, 16'h0,    2'h0, 0, 0, 1);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    1, 16'h1111, 2'h3, 0, 0, 0);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    1, 16'h2222, 2'h3, 0, 0, 0);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    1, 16'h3333, 2'h3, 0, 0, 0);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    1, 16'h4444, 2'h3, 1, 0, 1);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    0, 16'h0,    2'h0, 0, 0, 1);
    // Back-to-back beats, no gap between them
    row(1, 64'hA3A3_A2A2_A1A1_A0A0, 8'hFF, 0, 1, 1,  0, 16'h0,    2'h0, 0, 0, 1);
    row(1, 64'hB3B3_B2B2_B1B1_B0B0, 8'hFF, 1, 0, 1,  1, 16'hA0A0, 2'h3, 0, 1, 0);
    row(1, 64'hB3B3_B2B2_B1B1_B0B0, 8'hFF, 1, 0, 1,  1, 16'hA1A1, 2'h3, 0, 1, 0);
    row(1, 64'hB3B3_B2B2_B1B1_B0B0, 8'hFF, 1, 0, 1,  1, 16'hA2A2, 2'h3, 0, 1, 0);
    row(1, 64'hB3B3_B2B2_B1B1_B0B0, 8'hFF, 1, 0, 1,  1, 16'hA3A3, 2'h3, 0, 1, 1);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    1, 16'hB0B0, 2'h3, 0, 0, 0);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    1, 16'hB1B1, 2'h3, 0, 0, 0);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    1, 16'hB2B2, 2'h3, 0, 0, 0);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    1, 16'hB3B3, 2'h3, 1, 0, 1);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    0, 16'h0,    2'h0, 0, 0, 1);
    // Short trailing beat: keep 0x07 gives two lanes
    row(1, 64'h8888_7777_6666_5555, 8'h07, 1, 0, 1,  0, 16'h0,    2'h0, 0, 0, 1);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    1, 16'h5555, 2'h3, 0, 0, 0);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    1, 16'h6666, 2'h1, 1, 0, 1);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    0, 16'h0,    2'h0, 0, 0, 1);
    // All-zero keep: one lane with keep 0 carrying last and user
    row(1, 64'hDDDD_CCCC_BBBB_AAAA, 8'h00, 1, 1, 1,  0, 16'h0,    2'h0, 0, 0, 1);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    1, 16'hAAAA, 2'h0, 1, 1, 1);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    0, 16'h0,    2'h0, 0, 0, 1);
    // Backpressure, including a stall on the final lane
    row(1, 64'h5E5E_4E4E_3E3E_2E2E, 8'hFF, 0, 0, 0,  0, 16'h0,    2'h0, 0, 0, 1);
    row(1, 64'h1234_5678_9ABC_DEF0, 8'h03, 1, 1, 0,  1, 16'h2E2E, 2'h3, 0, 0, 0);
    row(1, 64'h1234_5678_9ABC_DEF0, 8'h03, 1, 1, 0,  1, 16'h2E2E, 2'h3, 0, 0, 0);
    row(1, 64'h1234_5678_9ABC_DEF0, 8'h03, 1, 1, 1,  1, 16'h2E2E, 2'h3, 0, 0, 0);
    row(1, 64'h1234_5678_9ABC_DEF0, 8'h03, 1, 1, 1,  1, 16'h3E3E, 2'h3, 0, 0, 0);
    row(1, 64'h1234_5678_9ABC_DEF0, 8'h03, 1, 1, 1,  1, 16'h4E4E, 2'h3, 0, 0, 0);
    row(1, 64'h1234_5678_9ABC_DEF0, 8'h03, 1, 1, 0,  1, 16'h5E5E, 2'h3, 0, 0, 0);
    row(1, 64'h1234_5678_9ABC_DEF0, 8'h03, 1, 1, 1,  1, 16'h5E5E, 2'h3, 0, 0, 1);
    row(0, 64'h0, 8'h00, 0, 0, 0,                    1, 16'hDEF0, 2'h3, 1, 1, 0);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    1, 16'hDEF0, 2'h3, 1, 1, 1);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    0, 16'h0,    2'h0, 0, 0, 1);
    // Non-contiguous keep: lanes up to the highest set lane, keep unmodified
    row(1, 64'h9999_8888_7777_6666, 8'h41, 0, 0, 1,  0, 16'h0,    2'h0, 0, 0, 1);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    1, 16'h6666, 2'h1, 0, 0, 0);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    1, 16'h7777, 2'h0, 0, 0, 0);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    1, 16'h8888, 2'h0, 0, 0, 0);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    1, 16'h9999, 2'h1, 0, 0, 1);
    row(0, 64'h0, 8'h00, 0, 0, 1,                    0, 16'h0,    2'h0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      s_valid = vecs[i].sv; s_data = vecs[i].sd; s_keep = vecs[i].sk;
      s_last  = vecs[i].sl; s_user = vecs[i].su; m_ready = vecs[i].mr;
      @(negedge clk);
      chk($sformatf("vec%0d m_valid", i), 64'(m_valid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d s_ready", i), 64'(s_ready), 64'(vecs[i].er));
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d m_data", i), 64'(m_data), 64'(vecs[i].ed));
        chk($sformatf("vec%0d m_keep", i), 64'(m_keep), 64'(vecs[i].ek));
        chk($sformatf("vec%0d m_last", i), 64'(m_last), 64'(vecs[i].el));
        chk($sformatf("vec%0d m_user", i), 64'(m_user), 64'(vecs[i].eu));
      end
      step();
    end

    // Synchronous clear during lane 2, then a fresh beat starts at lane 0
    s_data = 64'h7A7A_6A6A_5A5A_4A4A; s_keep = 8'hFF; s_last = 1'b1; s_user = 1'b0;
    s_valid = 1'b1; m_ready = 1'b1;
    step(); s_valid = 1'b0;
    step();
    step();
    rstn_local = 1'b0;
    @(negedge clk);
    chk("clr lane2 data", 64'(m_data), 64'h6A6A);
    step(); rstn_local = 1'b1;
    @(negedge clk);
    chk("clr m_valid", 64'(m_valid), 64'd0);
    chk("clr s_ready", 64'(s_ready), 64'd1);
    step();
    s_data = 64'hD3D3_D2D2_D1D1_D0D0; s_keep = 8'hFF; s_last = 1'b1; s_user = 1'b1; s_valid = 1'b1;
    step(); s_valid = 1'b0;
    @(negedge clk);
    chk("clr new m_valid", 64'(m_valid), 64'd1);
    chk("clr new lane0", 64'(m_data), 64'hD0D0);
    chk("clr new user", 64'(m_user), 64'd1);
    step();
    @(negedge clk);
    chk("clr new lane1", 64'(m_data), 64'hD1D1);
    step(); step(); step();
    @(negedge clk);
    chk("clr drained", 64'(m_valid), 64'd0);
    step();

    // Asynchronous reset mid-beat takes effect without a clock edge
    s_data = 64'hC3C3_C2C2_C1C1_C0C0; s_keep = 8'hFF; s_last = 1'b0; s_user = 1'b0; s_valid = 1'b1;
    step(); s_valid = 1'b0;
    step();
    @(negedge clk);
    chk("arst pre lane1", 64'(m_data), 64'hC1C1);
    #1 rstn = 1'b0;
    #1;
    chk("arst m_valid", 64'(m_valid), 64'd0);
    chk("arst s_ready", 64'(s_ready), 64'd1);
    @(negedge clk); rstn = 1'b1;
    step();
    @(negedge clk);
    chk("arst after", 64'(m_valid), 64'd0);
    step();

    // Randomized stream with random backpressure against the lane scoreboard
    gen = 0; cyc = 0; s_acc = 1'b0; stall_prev = 1'b0; hold_prev = '0;
    s_valid = 1'b0;
    while ((gen < 1000 || s_valid || exp_q.size() != 0) && cyc < 20000) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if (!s_valid || s_acc) begin
        if (gen < 1000 && $urandom_range(0, 4) != 0) begin
          s_data = {$urandom(), $urandom()};
          if ($urandom_range(0, 7) == 0) begin
            s_keep = 8'($urandom());
          end else begin
            nb = $urandom_range(0, 8);
            s_keep = 8'((9'h1 << nb) - 9'h1);
          end
          s_last = 1'($urandom_range(0, 1));
          s_user = 1'($urandom_range(0, 1));
          s_valid = 1'b1;
          gen++;
        end else begin
          s_valid = 1'b0;
        end
      end
      @(negedge clk);
      s_acc = s_valid && s_ready;
      if (s_acc) push_beat(s_data, s_keep, s_last, s_user[0]);
      if (stall_prev) begin
        chk("rand stall hold", 64'({m_valid, m_data, m_keep, m_last, m_user}), 64'({1'b1, hold_prev}));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rand lane: got unexpected lane 0x%0h expected none at %0t", m_data, $time);
        end else begin
          chk("rand lane", 64'({m_data, m_keep, m_last, m_user}), 64'(exp_q.pop_front()));
        end
      end
      stall_prev = m_valid && !m_ready;
      hold_prev  = {m_data, m_keep, m_last, m_user};
      step();
      cyc++;
    end
    n_cmp++;
    if (cyc >= 20000) begin
      n_bad++;
      $display("FAIL rand timeout: got %0d lanes pending, %0d beats generated, expected drain within 20000 cycles", exp_q.size(), gen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
